uart_frame_tx: RTL

//  Frame transmitter feeding the byte-wide UART transmitter (data/send/ready handshake).

---
 rtl/uart_frame_pkg.sv | 29 ++
 rtl/uart_frame_fifo.sv | 56 +++++
 rtl/uart_frame_tx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/uart_frame_pkg.sv
// Shared types, constants and the CRC-8 helper for the framed UART transmitter.
package uart_frame_pkg;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  typedef enum logic [1:0] {
    PH_SYNC,
    PH_LEN,
    PH_DATA,
    PH_CHK
  } phase_e;

  typedef enum logic [1:0] {
    ST_ISSUE,
    ST_GUARD,
    ST_WAIT
  } step_e;

  // CRC-8, polynomial 0x07, MSB first, one byte per call.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/uart_frame_fifo.sv
// Synchronous DEPTH x 8 payload FIFO with first-word-fall-through read data.
module uart_frame_fifo #(
  parameter int unsigned DEPTH = 16,
  localparam int unsigned AW = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [7:0]    data_i,
  input  logic          pop_i,
  output logic [7:0]    data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   level_o
);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign level_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_ONE;
      end else if (do_pop && !do_push) begin
        count_q <= count_q - CNT_ONE;
      end
    end
  end

  // Storage is not reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/uart_frame_tx.sv
// Frame transmitter: buffers payload, then sends SYNC, LEN, payload, CHK over a byte UART.
// Define UART_FRAME_CRC8_EN for a CRC-8 check byte; otherwise CHK is the byte sum mod 256.
module uart_frame_tx
  import uart_frame_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC_BYTE,
  localparam int unsigned AW       = $clog2(DEPTH)
) (
  input  logic          clk_in,
  input  logic          rst_n_in,
  input  logic [7:0]    wr_data_in,
  input  logic          wr_en_in,
  output logic          full_out,
  output logic [AW:0]   level_out,
  input  logic          go_in,
  output logic          busy_out,
  output logic          done_out,
  output logic          err_out,
  output logic [7:0]    tx_data_out,
  output logic          tx_send_out,
  input  logic          tx_ready_in
);

  phase_e      phase_q, phase_d;
  step_e       step_q, step_d;
  logic        busy_q, busy_d;
  logic [7:0]  len_q, len_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  chk_q, chk_d;
  logic [7:0]  tx_data_q, tx_data_d;
  logic        tx_send_q, tx_send_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        fifo_push;
  logic        fifo_pop;
  logic [7:0]  fifo_rd_data;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_level;
  logic [7:0]  cur_byte;
  logic [7:0]  chk_next;

  uart_frame_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk_in),
    .rst_ni  (rst_n_in),
    .push_i  (fifo_push),
    .data_i  (wr_data_in),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rd_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    case (phase_q)
      PH_SYNC: cur_byte = SYNC_BYTE;
      PH_LEN:  cur_byte = len_q;
      PH_DATA: cur_byte = fifo_rd_data;
      default: cur_byte = chk_q;
    endcase
  end

`ifdef UART_FRAME_CRC8_EN
  assign chk_next = crc8_step(chk_q, cur_byte);
`else
  assign chk_next = chk_q + cur_byte;
`endif

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      phase_q   <= PH_SYNC;
      step_q    <= ST_ISSUE;
      busy_q    <= 1'b0;
      len_q     <= '0;
      cnt_q     <= '0;
      chk_q     <= '0;
      tx_data_q <= '0;
      tx_send_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      step_q    <= step_d;
      busy_q    <= busy_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      chk_q     <= chk_d;
      tx_data_q <= tx_data_d;
      tx_send_q <= tx_send_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  // GUARD exists because tx_ready_in is still high the cycle after a send.
  always_comb begin
    phase_d   = phase_q;
    step_d    = step_q;
    busy_d    = busy_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    chk_d     = chk_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    done_d    = 1'b0;
    err_d     = wr_en_in && (busy_q || fifo_full);
    fifo_push = wr_en_in && !busy_q && !fifo_full;
    fifo_pop  = 1'b0;

    if (!busy_q) begin
      if (go_in) begin
        busy_d  = 1'b1;
        phase_d = PH_SYNC;
        step_d  = ST_ISSUE;
        chk_d   = '0;
        len_d   = 8'(fifo_level) + 8'(fifo_push);
      end
    end else begin
      unique case (step_q)
        ST_ISSUE: begin
          if (tx_ready_in) begin
            tx_data_d = cur_byte;
            tx_send_d = 1'b1;
            step_d    = ST_GUARD;
            if (phase_q == PH_LEN || phase_q == PH_DATA) chk_d = chk_next;
            if (phase_q == PH_DATA) fifo_pop = !fifo_empty;
          end
        end
        ST_GUARD: step_d = ST_WAIT;
        ST_WAIT: begin
          if (tx_ready_in) begin
            step_d = ST_ISSUE;
            case (phase_q)
              PH_SYNC: phase_d = PH_LEN;
              PH_LEN: begin
                cnt_d   = len_q;
                phase_d = (len_q == '0) ? PH_CHK : PH_DATA;
              end
              PH_DATA: begin
                cnt_d   = cnt_q - 8'd1;
                phase_d = (cnt_q == 8'd1) ? PH_CHK : PH_DATA;
              end
              default: begin
                phase_d = PH_SYNC;
                busy_d  = 1'b0;
                done_d  = 1'b1;
              end
            endcase
          end
        end
        default: step_d = ST_ISSUE;
      endcase
    end
  end

  assign full_out    = fifo_full;
  assign level_out   = fifo_level;
  assign busy_out    = busy_q;
  assign done_out    = done_q;
  assign err_out     = err_q;
  assign tx_data_out = tx_data_q;
  assign tx_send_out = tx_send_q;

endmodule
